// File: rtl/dma_utils_pkg.sv
// -----------------------------------------------------------------------------
// dma_utils_pkg
// Shared types and constants for the DMA write path.
//   DMA_DATA_WIDTH : default W-channel data width (64 bits).
//   dma_w_st_t     : W streamer FSM state encoding.
//   axi_len_t      : AXI burst length field (beats-1).
//   beat_cnt_t     : 9-bit beat counter. It can hold len+1 = 256.
//   is_final_beat  : true when a beat counter is at the last beat of a burst.
// -----------------------------------------------------------------------------
package dma_utils_pkg;

    localparam int DMA_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_STREAM = 2'd1,
        W_DONE   = 2'd2
    } dma_w_st_t;

    typedef logic [7:0] axi_len_t;
    typedef logic [8:0] beat_cnt_t;

    // A counter has reached the final beat when it equals len (beats-1).
    function automatic logic is_final_beat(input beat_cnt_t cnt, input axi_len_t len);
        return cnt == {1'b0, len};
    endfunction

endpackage

// File: rtl/dma_w_beat_reg.sv
// -----------------------------------------------------------------------------
// dma_w_beat_reg
// Single-entry holding register that drives the AXI4 W channel.
// A load captures a new beat. The register can accept a load when it is empty,
// or when its current beat is being handshaken in the same cycle. A handshake
// with no load empties the register. The held beat stays stable while it is
// stalled.
// Ports:
//   clk, rst         clock / asynchronous active-high reset
//   load_i           capture data_i/strb_i/last_i as the new beat
//   data_i, strb_i   beat payload
//   last_i           beat is the final beat of the burst
//   wready_i         AXI W ready
//   wvalid_o, wdata_o, wstrb_o, wlast_o   AXI W outputs (registered)
//   free_o           register can accept a load this cycle
//   hs_o             W handshake is taking place this cycle
// -----------------------------------------------------------------------------
module dma_w_beat_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [STRB_WIDTH-1:0] strb_i,
    input  logic                  last_i,
    input  logic                  wready_i,
    output logic                  wvalid_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [STRB_WIDTH-1:0] wstrb_o,
    output logic                  wlast_o,
    output logic                  free_o,
    output logic                  hs_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [STRB_WIDTH-1:0] strb_q,  strb_d;
    logic                  last_q,  last_d;

    assign hs_o   = valid_q && wready_i;
    assign free_o = !valid_q || wready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        if (load_i) begin
            // A load can coincide with a handshake. In that case the new beat
            // replaces the departing one, and valid stays high.
            valid_d = 1'b1;
            data_d  = data_i;
            strb_d  = strb_i;
            last_d  = last_i;
        end else if (valid_q && wready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    assign wvalid_o = valid_q;
    assign wdata_o  = data_q;
    assign wstrb_o  = strb_q;
    assign wlast_o  = last_q;

endmodule

// File: rtl/dma_w_streamer.sv
// -----------------------------------------------------------------------------
// dma_w_streamer
// Read-side consumer of the DMA data FIFO. It pops beats from the FIFO and
// drives them onto the AXI4 W channel. Each accepted command produces one
// burst, and WLAST is set on the final beat. A one-cycle done pulse follows the
// WLAST handshake.
// Optional feature: define DMA_W_STATS_EN to add beats_sent_o. This is a
// saturating 32-bit count of every W handshake, and only rst clears it.
// Ports:
//   clk, rst           clock / asynchronous active-high reset
//   cmd_valid_i        burst command valid
//   cmd_ready_o        command accepted (high only in IDLE)
//   cmd_len_i          AXI len (beats-1)
//   cmd_last_strb_i    strobe for the final beat (other beats use all-ones)
//   fifo_empty_i       FIFO empty flag
//   fifo_data_i        FIFO head data
//   fifo_rd_o          FIFO pop (never asserted while empty)
//   wvalid_o, wready_i, wdata_o, wstrb_o, wlast_o   AXI W channel
//   done_o             one-cycle pulse after the WLAST handshake
//   beats_sent_o       (DMA_W_STATS_EN only) W handshake count
// -----------------------------------------------------------------------------
module dma_w_streamer
    import dma_utils_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [7:0]            cmd_len_i,
    input  logic [STRB_WIDTH-1:0] cmd_last_strb_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [STRB_WIDTH-1:0] wstrb_o,
    output logic                  wlast_o,
    output logic                  done_o
`ifdef DMA_W_STATS_EN
    ,
    output logic [31:0]           beats_sent_o
`endif
);

    dma_w_st_t             state_q, state_d;
    axi_len_t              len_q, len_d;
    logic [STRB_WIDTH-1:0] last_strb_q, last_strb_d;
    beat_cnt_t             fetch_cnt_q, fetch_cnt_d;
    beat_cnt_t             sent_cnt_q, sent_cnt_d;

    logic                  beat_free;
    logic                  beat_hs;
    logic                  load;
    logic                  fetch_final;
    logic [STRB_WIDTH-1:0] beat_strb;

    // -------------------------------------------------------------------------
    // Fetch decision. Pop only while the burst still needs beats, the FIFO has
    // data, and the output register is empty or being drained this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        fetch_final = is_final_beat(fetch_cnt_q, len_q);
        load        = (state_q == W_STREAM)
                   && (fetch_cnt_q <= {1'b0, len_q})
                   && !fifo_empty_i
                   && beat_free;
        beat_strb   = fetch_final ? last_strb_q : '1;
    end

    assign fifo_rd_o = load;

    dma_w_beat_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_beat_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .data_i   (fifo_data_i),
        .strb_i   (beat_strb),
        .last_i   (fetch_final),
        .wready_i (wready_i),
        .wvalid_o (wvalid_o),
        .wdata_o  (wdata_o),
        .wstrb_o  (wstrb_o),
        .wlast_o  (wlast_o),
        .free_o   (beat_free),
        .hs_o     (beat_hs)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:   if (cmd_valid_i) state_d = W_STREAM;
            W_STREAM: if (beat_hs && wlast_o) state_d = W_DONE;
            W_DONE:   state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready_o = (state_q == W_IDLE);
        done_o      = (state_q == W_DONE);
    end

    // -------------------------------------------------------------------------
    // Command latch and beat counters
    // -------------------------------------------------------------------------
    always_comb begin
        len_d       = len_q;
        last_strb_d = last_strb_q;
        fetch_cnt_d = fetch_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        case (state_q)
            W_IDLE: begin
                if (cmd_valid_i) begin
                    len_d       = cmd_len_i;
                    last_strb_d = cmd_last_strb_i;
                    fetch_cnt_d = '0;
                    sent_cnt_d  = '0;
                end
            end
            W_STREAM: begin
                if (load)    fetch_cnt_d = fetch_cnt_q + 9'd1;
                if (beat_hs) sent_cnt_d  = sent_cnt_q + 9'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            last_strb_q <= '0;
            fetch_cnt_q <= '0;
            sent_cnt_q  <= '0;
        end else begin
            len_q       <= len_d;
            last_strb_q <= last_strb_d;
            fetch_cnt_q <= fetch_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
        end
    end

`ifdef DMA_W_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating W handshake counter
    // -------------------------------------------------------------------------
    logic [31:0] beats_q, beats_d;

    always_comb begin
        beats_d = beats_q;
        if (beat_hs && (beats_q != 32'hFFFF_FFFF)) beats_d = beats_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

    assign beats_sent_o = beats_q;
`endif

endmodule
